// File: rtl/clkgen_prog_receiver_pkg.sv
// -----------------------------------------------------------------------------
// clkgen_prog_receiver_pkg
// Shared definitions for the clkgen serial programming receiver: FSM state
// encoding, frame geometry, command bit encodings and the field-to-value
// helper used to drive the active M/D outputs.
// -----------------------------------------------------------------------------
package clkgen_prog_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_GO_WAIT = 2'd2
  } state_t;

  // Load frame length in bits; the bit counter saturates one above this so an
  // over-long frame stays distinguishable from a correct one.
  localparam int FRAME_LEN = 10;
  localparam int FIELD_W   = 8;
  localparam int CNT_W     = 4;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_LEN + 1);

  // Bit 0 of a frame: command type. Bit 1 of a load frame: target register.
  localparam logic CMD_LOAD = 1'b1;
  localparam logic CMD_GO   = 1'b0;
  localparam logic SEL_D    = 1'b0;
  localparam logic SEL_M    = 1'b1;

  // Stored fields hold value-1; widen before adding so 0xFF maps to 256.
  function automatic logic [FIELD_W:0] field_to_val(input logic [FIELD_W-1:0] f);
    return {1'b0, f} + (FIELD_W + 1)'(1);
  endfunction

endpackage

// File: rtl/clkgen_prog_receiver.sv
// -----------------------------------------------------------------------------
// clkgen_prog_receiver
// Receiving end of the clkgen serial programming port. Load frames stage new
// M/D fields into pending registers; a GO frame starts a GO_LATENCY countdown
// after which pending values become active and update_o pulses once.
//
// Framing: a frame is every consecutive cycle with progen_i=1; progdata_i is
// sampled on each such cycle and the first progen_i=0 cycle ends the frame.
// There is no back-pressure: the sender may start a new frame at any time.
//
// Ports
//   clk_usb      in   clock, all logic on the rising edge
//   reset_n      in   asynchronous active-low reset
//   progen_i     in   serial program enable (frame strobe)
//   progdata_i   in   serial program data, LSB first
//   err_clr_i    in   clears err_o (a same-cycle new error wins)
//   progdone_o   out  high when idle with nothing pending
//   mult_o[8:0]  out  active M value (2-256)
//   div_o[8:0]   out  active D value (1-256)
//   update_o     out  one-cycle pulse when active values are applied
//   err_o        out  sticky malformed-frame flag
//   dbg_state_o  out  current FSM state (state_t encoding), observation only
// -----------------------------------------------------------------------------
module clkgen_prog_receiver
  import clkgen_prog_receiver_pkg::*;
#(
  parameter int GO_LATENCY = 4,
  parameter int M_DEFAULT  = 2,
  parameter int D_DEFAULT  = 2
) (
  input  logic       clk_usb,
  input  logic       reset_n,
  input  logic       progen_i,
  input  logic       progdata_i,
  input  logic       err_clr_i,
  output logic       progdone_o,
  output logic [8:0] mult_o,
  output logic [8:0] div_o,
  output logic       update_o,
  output logic       err_o,
  output logic [1:0] dbg_state_o
);

  localparam logic [FIELD_W-1:0] M_RST  = FIELD_W'(M_DEFAULT - 1);
  localparam logic [FIELD_W-1:0] D_RST  = FIELD_W'(D_DEFAULT - 1);
  localparam logic [CNT_W-1:0]   GO_LAT = CNT_W'(GO_LATENCY);

  state_t               r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_bit0;
  logic [FRAME_LEN-1:0] r_shift;
  logic [CNT_W-1:0]     r_go_cnt;
  logic [FIELD_W-1:0]   r_pend_m;
  logic [FIELD_W-1:0]   r_pend_d;
  logic [FIELD_W-1:0]   r_act_m;
  logic [FIELD_W-1:0]   r_act_d;
  logic                 r_progdone;
  logic                 r_update;
  logic                 r_err;

  logic w_frame_end;
  logic w_load_ok;
  logic w_go_ok;
  logic w_bad_frame;
  logic w_go_intrude;
  logic w_err_set;

  // Frame classification happens on the cycle progen_i drops in SHIFT.
  assign w_frame_end  = (r_state == ST_SHIFT) && !progen_i;
  assign w_load_ok    = w_frame_end && (r_bit_cnt == CNT_FRAME) && (r_bit0 == CMD_LOAD);
  assign w_go_ok      = w_frame_end && (r_bit_cnt == CNT_ONE) && (r_bit0 == CMD_GO);
  assign w_bad_frame  = w_frame_end && !w_load_ok && !w_go_ok;
  // A frame started while a GO is counting down is dropped, not decoded.
  assign w_go_intrude = (r_state == ST_GO_WAIT) && progen_i;
  assign w_err_set    = w_bad_frame || w_go_intrude;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_bit0     <= 1'b0;
      r_shift    <= '0;
      r_go_cnt   <= '0;
      r_pend_m   <= M_RST;
      r_pend_d   <= D_RST;
      r_act_m    <= M_RST;
      r_act_d    <= D_RST;
      r_progdone <= 1'b1;
      r_update   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (progen_i) begin
            r_state    <= ST_SHIFT;
            r_bit0     <= progdata_i;
            // Right shift: after exactly FRAME_LEN samples bit0 lands at [0].
            r_shift    <= {progdata_i, {(FRAME_LEN-1){1'b0}}};
            r_bit_cnt  <= CNT_ONE;
            r_progdone <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (progen_i) begin
            r_shift <= {progdata_i, r_shift[FRAME_LEN-1:1]};
            if (r_bit_cnt != CNT_SAT) begin
              r_bit_cnt <= r_bit_cnt + CNT_ONE;
            end
          end else if (w_load_ok) begin
            if (r_shift[1] == SEL_M) begin
              r_pend_m <= r_shift[FRAME_LEN-1 -: FIELD_W];
            end else begin
              r_pend_d <= r_shift[FRAME_LEN-1 -: FIELD_W];
            end
            r_state <= ST_IDLE;
          end else if (w_go_ok) begin
            r_go_cnt <= GO_LAT;
            r_state  <= ST_GO_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GO_WAIT: begin
          // Apply on the cycle the counter steps to zero; stray progen_i
          // activity only raises err_o and never touches the countdown.
          r_go_cnt <= r_go_cnt - CNT_ONE;
          if (r_go_cnt <= CNT_ONE) begin
            r_act_m    <= r_pend_m;
            r_act_d    <= r_pend_d;
            r_update   <= 1'b1;
            r_progdone <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Set has priority over clear.
      r_err <= w_err_set || (r_err && !err_clr_i);
    end
  end

  assign progdone_o  = r_progdone;
  assign update_o    = r_update;
  assign err_o       = r_err;
  assign mult_o      = field_to_val(r_act_m);
  assign div_o       = field_to_val(r_act_d);
  assign dbg_state_o = r_state;

endmodule

// File: doc/clkgen_prog_receiver.md
CLKGEN_PROG_RECEIVER -- requirements
Module: clkgen_prog_receiver

Interface
REQ-001 SHALL have parameter GO_LATENCY, default 4, meaning clk_usb cycles from GO decode to apply (range 1-15).
REQ-002 SHALL have parameter M_DEFAULT, default 2, meaning active multiply value after reset (range 2-256).
REQ-003 SHALL have parameter D_DEFAULT, default 2, meaning active divide value after reset (range 1-256).
REQ-004 SHALL have port clk_usb  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port progen_i  input  1  serial program enable.
REQ-007 SHALL have port progdata_i  input  1  serial program data.
REQ-008 SHALL have port err_clr_i  input  1  clears err_o.
REQ-009 SHALL have port progdone_o  output  1  high when idle with no pending programming.
REQ-010 SHALL have port mult_o  output  9  active M (field+1, 2-256).
REQ-011 SHALL have port div_o  output  9  active D (field+1, 1-256).
REQ-012 SHALL have port update_o  output  1  one-cycle pulse when the active values are applied.
REQ-013 SHALL have port err_o  output  1  sticky malformed-frame flag.

Function
REQ-014 Protocol SHALL be the receiving end of the clkgen serial programming port: a frame is a contiguous run of cycles with progen_i=1, and progdata_i is sampled on each of those cycles.
REQ-015 A load frame SHALL be exactly 10 bits: bit0=1, bit1 selects the target (0=D, 1=M), and bits 2-9 are the 8-bit field (value-1), LSB first.
REQ-016 A GO frame SHALL be exactly 1 bit with progdata_i=0.
REQ-017 States SHALL be IDLE, SHIFT and GO_WAIT.
REQ-018 IDLE->SHIFT SHALL occur on progen_i=1, capturing bit0 and setting bit count=1.
REQ-019 In SHIFT, each progen_i=1 cycle SHALL shift in one bit and increment the count, saturating at 11.
REQ-020 SHIFT exit SHALL occur on the first progen_i=0 cycle: count=10 with bit0=1 -> write pending M or D, go to IDLE; count=1 with bit0=0 -> go to GO_WAIT, loading a down-counter with GO_LATENCY; any other count/bit0 combination -> set err_o, discard the frame, go to IDLE.
REQ-021 progdone_o SHALL fall in the cycle after the first progen_i=1 sample in IDLE, stay low through load frames, and rise only on GO completion.
REQ-022 GO_WAIT SHALL decrement each cycle; on the cycle the count reaches 0 it SHALL copy pending M/D to active, pulse update_o for one cycle, raise progdone_o and return to IDLE (GO->update latency = GO_LATENCY+1 cycles after the GO bit).
REQ-023 progen_i=1 during GO_WAIT SHALL set err_o, be ignored, and SHALL NOT extend or abort GO_WAIT.
REQ-024 mult_o/div_o SHALL change only with update_o and SHALL equal the active field+1 (9-bit zero-extended add, no overflow).
REQ-025 A GO with no preceding load SHALL re-apply the unchanged pending values and still pulse update_o.
REQ-026 err_clr_i SHALL clear err_o; if a new error occurs in the same cycle, the error wins and err_o stays 1.

Reset
REQ-027 While reset_n=0: state=IDLE, count=0, progdone_o=1, update_o=0, err_o=0, active and pending M=M_DEFAULT-1 and D=D_DEFAULT-1 (so mult_o=M_DEFAULT, div_o=D_DEFAULT).
REQ-028 Reset asserted mid-frame or mid-GO_WAIT SHALL abandon that operation with no update_o pulse.

Structure
REQ-029 The shared package SHALL hold the state enum, FRAME_LEN=10, command bit encodings (LOAD=1, GO=0, SEL_D=0, SEL_M=1) and the field width 8.
REQ-030 The block SHALL be a single module with no sub-module; the shifter, counter and FSM SHALL be inline.

Verification
REQ-031 Reset, then idle -> mult_o=2, div_o=2, progdone_o=1, err_o=0.
REQ-032 LoadM field 0x09, LoadD field 0x03, then GO -> progdone_o low from the first frame; update_o pulses 5 cycles after the GO bit; mult_o=10, div_o=4, progdone_o=1.
REQ-033 A 9-bit frame, then an 11-bit frame -> err_o=1 after each, pending values unchanged, no update_o; err_clr_i -> err_o=0.
REQ-034 A GO bit, then progen_i high 2 cycles later during GO_WAIT -> err_o=1, update_o still exactly 5 cycles after GO.
REQ-035 reset_n low at GO_WAIT count 2 -> no update_o, outputs return to reset values.
REQ-036 LoadM field 0xFF, LoadD field 0x00, then GO -> mult_o=256, div_o=1.
